// File: rtl/wb_bus_arbiter.sv
// ============================================================================
// wb_bus_arbiter: shares one Wishbone slave port between CPU ibus and dbus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_bus_arbiter #(
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] ibus__adr,
  input  logic [31:0] ibus__dat_w,
  output logic [31:0] ibus__dat_r,
  input  logic [3:0]  ibus__sel,
  input  logic        ibus__cyc,
  input  logic        ibus__stb,
  input  logic        ibus__we,
  output logic        ibus__ack,
  output logic        ibus__err,
  input  logic [29:0] dbus__adr,
  input  logic [31:0] dbus__dat_w,
  output logic [31:0] dbus__dat_r,
  input  logic [3:0]  dbus__sel,
  input  logic        dbus__cyc,
  input  logic        dbus__stb,
  input  logic        dbus__we,
  output logic        dbus__ack,
  output logic        dbus__err,
  output logic [29:0] mem__adr,
  output logic [31:0] mem__dat_w,
  input  logic [31:0] mem__dat_r,
  output logic [3:0]  mem__sel,
  output logic        mem__cyc,
  output logic        mem__stb,
  output logic        mem__we,
  input  logic        mem__ack,
  input  logic        mem__err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam bit         WD_EN   = (TIMEOUT != 0);
  localparam logic [7:0] WD_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit         RR_EN   = (ROUND_ROBIN != 0);

  state_t     state_q, state_d;
  logic       last_d_q, last_d_d;   // 1 = dbus held the most recent grant
  logic [7:0] wd_q, wd_d;
  logic       sel_cyc, sel_stb, wd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wd_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    case (state_q)
      GRANT_I: begin sel_cyc = ibus__cyc; sel_stb = ibus__stb; end
      GRANT_D: begin sel_cyc = dbus__cyc; sel_stb = dbus__stb; end
      default: ;
    endcase
    // A slave response in the same cycle wins over the timeout; reset abandons.
    wd_fire = WD_EN && sel_stb && !mem__ack && !mem__err && !rst && (wd_q == WD_LAST);
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = 8'd0;
        if (ibus__cyc && dbus__cyc) begin
          state_d = (RR_EN && last_d_q) ? GRANT_I : GRANT_D;
        end else if (dbus__cyc) begin
          state_d = GRANT_D;
        end else if (ibus__cyc) begin
          state_d = GRANT_I;
        end
        if (state_d == GRANT_D) last_d_d = 1'b1;
        if (state_d == GRANT_I) last_d_d = 1'b0;
      end
      GRANT_I, GRANT_D: begin
        if (!sel_cyc) state_d = IDLE;
        if (!sel_stb || mem__ack || mem__err || wd_fire) begin
          wd_d = 8'd0;
        end else if (wd_q != 8'hFF) begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem__adr   = '0;
    mem__dat_w = '0;
    mem__sel   = '0;
    mem__cyc   = 1'b0;
    mem__stb   = 1'b0;
    mem__we    = 1'b0;
    case (state_q)
      GRANT_I: begin
        mem__adr   = ibus__adr;
        mem__dat_w = ibus__dat_w;
        mem__sel   = ibus__sel;
        mem__cyc   = ibus__cyc;
        mem__stb   = ibus__stb && !wd_fire;
        mem__we    = ibus__we;
      end
      GRANT_D: begin
        mem__adr   = dbus__adr;
        mem__dat_w = dbus__dat_w;
        mem__sel   = dbus__sel;
        mem__cyc   = dbus__cyc;
        mem__stb   = dbus__stb && !wd_fire;
        mem__we    = dbus__we;
      end
      default: ;
    endcase
  end

  assign ibus__dat_r = mem__dat_r;
  assign dbus__dat_r = mem__dat_r;
  assign ibus__ack = (state_q == GRANT_I) && ibus__stb && mem__ack && !rst;
  assign ibus__err = (state_q == GRANT_I) && ibus__stb && (mem__err || wd_fire) && !rst;
  assign dbus__ack = (state_q == GRANT_D) && dbus__stb && mem__ack && !rst;
  assign dbus__err = (state_q == GRANT_D) && dbus__stb && (mem__err || wd_fire) && !rst;

endmodule

`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
// ============================================================================
// tb_wb_bus_arbiter: directed + random checks of two arbiter configurations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_bus_arbiter;

  localparam int RR0 = 0, TO0 = 4;   // fixed priority, short watchdog
  localparam int RR1 = 1, TO1 = 0;   // round robin, watchdog disabled

  typedef logic [136:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [29:0] i_adr, d_adr;
  logic [31:0] i_dw, d_dw, mem_dr;
  logic [3:0]  i_sel, d_sel;
  logic i_cyc, i_stb, i_we, d_cyc, d_stb, d_we, mem_ack, mem_err;

  logic [31:0] o_idr [2];
  logic [31:0] o_ddr [2];
  logic [31:0] o_mdw [2];
  logic [29:0] o_madr [2];
  logic [3:0]  o_msel [2];
  logic o_iack [2], o_ierr [2], o_dack [2], o_derr [2];
  logic o_mcyc [2], o_mstb [2], o_mwe [2];

  always #5 clk = ~clk;

  wb_bus_arbiter #(.ROUND_ROBIN(RR0), .TIMEOUT(TO0)) u_dut0 (
    .clk(clk), .rst(rst),
    .ibus__adr(i_adr), .ibus__dat_w(i_dw), .ibus__dat_r(o_idr[0]), .ibus__sel(i_sel),
    .ibus__cyc(i_cyc), .ibus__stb(i_stb), .ibus__we(i_we), .ibus__ack(o_iack[0]), .ibus__err(o_ierr[0]),
    .dbus__adr(d_adr), .dbus__dat_w(d_dw), .dbus__dat_r(o_ddr[0]), .dbus__sel(d_sel),
    .dbus__cyc(d_cyc), .dbus__stb(d_stb), .dbus__we(d_we), .dbus__ack(o_dack[0]), .dbus__err(o_derr[0]),
    .mem__adr(o_madr[0]), .mem__dat_w(o_mdw[0]), .mem__dat_r(mem_dr), .mem__sel(o_msel[0]),
    .mem__cyc(o_mcyc[0]), .mem__stb(o_mstb[0]), .mem__we(o_mwe[0]), .mem__ack(mem_ack), .mem__err(mem_err)
  );

  wb_bus_arbiter #(.ROUND_ROBIN(RR1), .TIMEOUT(TO1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ibus__adr(i_adr), .ibus__dat_w(i_dw), .ibus__dat_r(o_idr[1]), .ibus__sel(i_sel),
    .ibus__cyc(i_cyc), .ibus__stb(i_stb), .ibus__we(i_we), .ibus__ack(o_iack[1]), .ibus__err(o_ierr[1]),
    .dbus__adr(d_adr), .dbus__dat_w(d_dw), .dbus__dat_r(o_ddr[1]), .dbus__sel(d_sel),
    .dbus__cyc(d_cyc), .dbus__stb(d_stb), .dbus__we(d_we), .dbus__ack(o_dack[1]), .dbus__err(o_derr[1]),
    .mem__adr(o_madr[1]), .mem__dat_w(o_mdw[1]), .mem__dat_r(mem_dr), .mem__sel(o_msel[1]),
    .mem__cyc(o_mcyc[1]), .mem__stb(o_mstb[1]), .mem__we(o_mwe[1]), .mem__ack(mem_ack), .mem__err(mem_err)
  );

  // Reference model: owner 0 = nobody, 1 = ibus, 2 = dbus; stall = cycles waited so far.
  int owner [2];
  int last  [2];
  int stall [2];
  bit mdl_valid = 1'b0;

  int n_pass = 0, n_total = 0, n_fail = 0;
  logic s_iack [2], s_ierr [2], s_dack [2], s_derr [2], s_mcyc [2], s_mstb [2];
  logic [29:0] s_madr [2];
  logic [31:0] s_idr [2];
  int cnt_iack [2], cnt_ierr [2], cnt_dack [2], cnt_derr [2];

  function automatic int rr_of(input int k);
    return (k == 0) ? RR0 : RR1;
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? TO0 : TO1;
  endfunction

  function automatic logic fires(input int k, input logic xs);
    return (to_of(k) != 0) && xs && !mem_ack && !mem_err && !rst && (stall[k] + 1 == to_of(k));
  endfunction

  function automatic vec_t expv(input int k);
    logic [29:0] a;
    logic [31:0] dw;
    logic [3:0]  sl;
    logic c, w, xs, f, ak, er;
    a = '0; dw = '0; sl = '0; c = 1'b0; w = 1'b0; xs = 1'b0;
    if (owner[k] == 1) begin
      a = i_adr; dw = i_dw; sl = i_sel; c = i_cyc; w = i_we; xs = i_stb;
    end else if (owner[k] == 2) begin
      a = d_adr; dw = d_dw; sl = d_sel; c = d_cyc; w = d_we; xs = d_stb;
    end
    f  = fires(k, xs);
    ak = xs && mem_ack && !rst;
    er = xs && (mem_err || f) && !rst;
    return {a, dw, sl, c, xs && !f, w,
            (owner[k] == 1) && ak, (owner[k] == 1) && er,
            (owner[k] == 2) && ak, (owner[k] == 2) && er, mem_dr, mem_dr};
  endfunction

  function automatic vec_t obsv(input int k);
    return {o_madr[k], o_mdw[k], o_msel[k], o_mcyc[k], o_mstb[k], o_mwe[k],
            o_iack[k], o_ierr[k], o_dack[k], o_derr[k], o_idr[k], o_ddr[k]};
  endfunction

  task automatic mdl_update();
    for (int k = 0; k < 2; k++) begin
      logic xs, xc, f;
      int win;
      if (rst) begin
        owner[k] = 0; last[k] = 1; stall[k] = 0; mdl_valid = 1'b1;
      end else if (owner[k] == 0) begin
        stall[k] = 0;
        win = 0;
        if (i_cyc && d_cyc) win = (rr_of(k) != 0 && last[k] == 2) ? 1 : 2;
        else if (d_cyc)     win = 2;
        else if (i_cyc)     win = 1;
        if (win != 0) begin owner[k] = win; last[k] = win; end
      end else begin
        xs = (owner[k] == 1) ? i_stb : d_stb;
        xc = (owner[k] == 1) ? i_cyc : d_cyc;
        f  = fires(k, xs);
        stall[k] = (xs && !mem_ack && !mem_err && !f) ? stall[k] + 1 : 0;
        if (!xc) owner[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 2; k++) begin
      cnt_iack[k] = 0; cnt_ierr[k] = 0; cnt_dack[k] = 0; cnt_derr[k] = 0;
    end
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vec_t e;
      e = expv(k);
      if (mdl_valid) begin
        n_total++;
        assert (obsv(k) === e) n_pass++;
        else begin
          n_fail++;
          $error("FAIL model dut%0d observed=%h expected=%h", k, obsv(k), e);
        end
      end
      s_iack[k] = o_iack[k]; s_ierr[k] = o_ierr[k];
      s_dack[k] = o_dack[k]; s_derr[k] = o_derr[k];
      s_mcyc[k] = o_mcyc[k]; s_mstb[k] = o_mstb[k];
      s_madr[k] = o_madr[k]; s_idr[k]  = o_idr[k];
      cnt_iack[k] += int'(o_iack[k]); cnt_ierr[k] += int'(o_ierr[k]);
      cnt_dack[k] += int'(o_dack[k]); cnt_derr[k] += int'(o_derr[k]);
    end
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  task automatic quiet();
    i_cyc = 0; i_stb = 0; i_we = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    mem_ack = 0; mem_err = 0;
  endtask

  initial begin
    logic [3:0] g [2];
    int first [2];
    logic wd_stb;
    int wd_first;

    rst = 1; quiet();
    i_adr = '0; d_adr = '0; i_dw = '0; d_dw = '0; i_sel = '0; d_sel = '0; mem_dr = '0;
    #1;
    cycle(); cycle();
    rst = 0;

    // Idle after reset
    clr_cnt();
    for (int n = 0; n < 10; n++) begin
      cycle();
      for (int k = 0; k < 2; k++) chk($sformatf("idle_cyc%0d", k), 32'(s_mcyc[k]), 0);
    end
    chk("idle_ackerr", 32'(cnt_iack[0] + cnt_ierr[0] + cnt_dack[0] + cnt_derr[0] +
                           cnt_iack[1] + cnt_ierr[1] + cnt_dack[1] + cnt_derr[1]), 0);

    // Single ibus read
    clr_cnt();
    i_cyc = 1; i_stb = 1; i_adr = 30'h100; i_sel = 4'hF;
    cycle();
    chk("rd_lat0", 32'(s_mcyc[0]), 0);
    cycle();
    chk("rd_cyc", 32'(s_mcyc[0]), 1);
    chk("rd_adr", 32'(s_madr[0]), 32'h100);
    mem_ack = 1; mem_dr = 32'hDEADBEEF;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_ack%0d", k), 32'(s_iack[k]), 1);
      chk($sformatf("rd_dat%0d", k), s_idr[k], 32'hDEADBEEF);
    end
    quiet();
    cycle(); cycle();
    chk("rd_idle", 32'(s_mcyc[0]), 0);
    chk("rd_ackcnt", 32'(cnt_iack[0]), 1);

    // Simultaneous requests: grant order per configuration
    g[0] = '0; g[1] = '0;
    i_adr = 30'h1; d_adr = 30'h2;
    for (int r = 0; r < 4; r++) begin
      i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
      cycle(); cycle();
      for (int k = 0; k < 2; k++) g[k][r] = (s_madr[k] == 30'h2);
      quiet();
      cycle(); cycle();
    end
    chk("prio_fixed", 32'(g[0]), 32'hF);
    chk("prio_rr", 32'(g[1]), 32'h5);

    // Grant held across dbus strobes while ibus waits
    clr_cnt();
    d_cyc = 1; d_stb = 1; mem_ack = 1;
    cycle();
    i_cyc = 1; i_stb = 1;
    for (int s = 0; s < 3; s++) begin
      d_stb = 1; cycle();
      d_stb = 0; cycle();
    end
    chk("hold_dack", 32'(cnt_dack[0]), 3);
    chk("hold_iack", 32'(cnt_iack[0] + cnt_iack[1]), 0);
    d_cyc = 0; d_stb = 0;
    first[0] = -1; first[1] = -1;
    for (int n = 0; n < 4; n++) begin
      cycle();
      for (int k = 0; k < 2; k++) if (s_iack[k] && first[k] < 0) first[k] = n;
    end
    chk("hold_gap0", 32'(first[0]), 2);
    chk("hold_gap1", 32'(first[1]), 2);
    quiet();
    cycle(); cycle();

    // Watchdog: slave never answers a dbus read
    clr_cnt();
    d_cyc = 1; d_stb = 1; i_cyc = 1; i_stb = 1;
    cycle();
    wd_first = 0; wd_stb = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      cycle();
      if (s_derr[0] && wd_first == 0) begin wd_first = n; wd_stb = s_mstb[0]; end
    end
    chk("wd_cycle", 32'(wd_first), 4);
    chk("wd_stb", 32'(wd_stb), 0);
    chk("wd_count", 32'(cnt_derr[0]), 1);
    for (int n = 0; n < 300; n++) cycle();
    chk("wd_off", 32'(cnt_derr[1] + cnt_ierr[1]), 0);
    chk("wd_noierr", 32'(cnt_ierr[0]), 0);
    quiet();
    cycle(); cycle(); cycle();

    // Reset in the middle of a stalled dbus write
    d_cyc = 1; d_stb = 1; d_we = 1; d_dw = 32'h12345678; d_adr = 30'h2A;
    cycle(); cycle();
    chk("rstw_cyc", 32'(s_mcyc[0]), 1);
    clr_cnt();
    rst = 1;
    cycle();
    rst = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    i_cyc = 1; i_stb = 1;
    cycle();
    chk("rstw_idle", 32'(s_mcyc[0] | s_mcyc[1]), 0);
    chk("rstw_noresp", 32'(cnt_dack[0] + cnt_derr[0] + cnt_dack[1] + cnt_derr[1]), 0);
    mem_ack = 1;
    cycle();
    chk("rstw_iack0", 32'(s_iack[0]), 1);
    chk("rstw_iack1", 32'(s_iack[1]), 1);
    quiet();
    cycle(); cycle();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) i_cyc = ~i_cyc;
      if ($urandom_range(0, 3) == 0) d_cyc = ~d_cyc;
      i_stb = i_cyc & ($urandom_range(0, 2) != 0);
      d_stb = d_cyc & ($urandom_range(0, 2) != 0);
      i_we = 1'($urandom); d_we = 1'($urandom);
      i_adr = 30'($urandom); d_adr = 30'($urandom);
      i_dw = $urandom; d_dw = $urandom; mem_dr = $urandom;
      i_sel = 4'($urandom); d_sel = 4'($urandom);
      mem_ack = ($urandom_range(0, 4) == 0);
      mem_err = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
